encoder_8b10b_lanes: RTL and testbench

- Parametrised 8b/10b encoder; successor to the 5b/6b sub-block encoder.
- Combines the 5b/6b and 3b/4b sub-blocks and tracks running disparity internally, so no external complement control is needed.
- Supports LANES bytes per clock with disparity chained across lanes.
- Supports K-code validation, RD override and a valid handshake.
- Sits between the TMDS/serialiser byte source and the 10-bit serialiser.

---
 rtl/encoder_8b10b_lanes.sv | 167 ++++++++++++++++
 tb/tb_encoder_8b10b_lanes.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/encoder_8b10b_lanes.sv
// Multi-lane 8b/10b encoder with internal running-disparity tracking.
// Lane 0 is encoded first; disparity chains from lane to lane within a word.
// One cycle of latency, all outputs registered.
module encoder_8b10b_lanes #(
    parameter int unsigned LANES   = 1,
    parameter bit          INIT_RD = 1'b0
) (
    input  logic                  SBYTECLK,
    input  logic                  RESET,
    input  logic                  DIN_VALID,
    input  logic [8*LANES-1:0]    DIN,
    input  logic [LANES-1:0]      KIN,
    input  logic                  FORCE_RD_EN,
    input  logic                  FORCE_RD,
    output logic                  DOUT_VALID,
    output logic [10*LANES-1:0]   DOUT,
    output logic                  RD_OUT,
    output logic [LANES-1:0]      KERR
);

    // 5b/6b RD- forms written abcdei (a is the MSB of the literal).
    function automatic logic [5:0] tbl6(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b RD- forms written fghj; y=7 is the primary P7 form.
    function automatic logic [3:0] tbl4(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // K.28.0-7, K.23.7, K.27.7, K.29.7, K.30.7.
    function automatic logic k_legal(input logic [7:0] d);
        return (d[4:0] == 5'd28) || (d == 8'hF7) || (d == 8'hFB) ||
               (d == 8'hFD) || (d == 8'hFE);
    endfunction

    // Returns {ending RD, 10-bit code in DOUT bit order (bit0 = a ... bit9 = j)}.
    function automatic logic [10:0] encode_lane(input logic [7:0] d, input logic k,
                                                input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       kl, k28, bal6, bal4, rd_mid, rd_end, a7;
        logic [5:0] c6;
        logic [3:0] c4;
        x   = d[4:0];
        y   = d[7:5];
        kl  = k && k_legal(d);
        k28 = kl && (x == 5'd28);

        c6   = k28 ? 6'b001111 : tbl6(x);
        bal6 = ($countones(c6) == 3);
        // D.7 is balanced but still has distinct RD-/RD+ forms.
        if (rd && (!bal6 || x == 5'd7)) c6 = ~c6;
        rd_mid = bal6 ? rd : ~rd;

        // Alternate 7 avoids a run of five equal bits across the e/i-f/g boundary.
        a7 = (y == 3'd7) &&
             (kl ||
              (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        c4   = a7 ? 4'b0111 : tbl4(y);
        bal4 = ($countones(c4) == 2);
        if (rd_mid && (!bal4 || y == 3'd3)) c4 = ~c4;
        // K.28.1/.5/.6 invert the balanced data form when entering RD-.
        if (k28 && !rd_mid && (y == 3'd1 || y == 3'd5 || y == 3'd6)) c4 = ~c4;
        rd_end = bal4 ? rd_mid : ~rd_mid;

        return {rd_end, c4[0], c4[1], c4[2], c4[3],
                c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    endfunction

    logic                  rd_q;
    logic                  rd_end;
    logic [10*LANES-1:0]   enc_word;
    logic [LANES-1:0]      kerr_word;
    logic [10*LANES-1:0]   dout_q;
    logic                  valid_q;
    logic [LANES-1:0]      kerr_q;

    // Encode every lane, chaining disparity from lane 0 upward.
    always_comb begin : p_encode
        logic        rd_run;
        logic [10:0] res;
        enc_word  = '0;
        kerr_word = '0;
        res       = '0;
        rd_run    = FORCE_RD_EN ? FORCE_RD : rd_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            res                  = encode_lane(DIN[8*i +: 8], KIN[i], rd_run);
            enc_word[10*i +: 10] = res[9:0];
            rd_run               = res[10];
            kerr_word[i]         = KIN[i] && !k_legal(DIN[8*i +: 8]);
        end
        rd_end = rd_run;
    end

    // Output and disparity registers; idle cycles hold DOUT/KERR.
    always_ff @(posedge SBYTECLK or posedge RESET) begin
        if (RESET) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            kerr_q  <= '0;
            rd_q    <= INIT_RD;
        end else begin
            valid_q <= DIN_VALID;
            if (DIN_VALID) begin
                dout_q <= enc_word;
                kerr_q <= kerr_word;
                rd_q   <= rd_end;
            end else if (FORCE_RD_EN) begin
                rd_q <= FORCE_RD;
            end
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = valid_q;
    assign KERR       = kerr_q;
    assign RD_OUT     = rd_q;

endmodule

// File: tb/tb_encoder_8b10b_lanes.sv
// Directed bench for encoder_8b10b_lanes: one single-lane and one dual-lane instance.
// Expected codes are written abcdei_fghj (a leftmost) and bit-reversed into DOUT order.
module tb_encoder_8b10b_lanes;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v1, kin1, fen1, frd1;
    logic [7:0]  din1;
    logic        dv1, rd1, kerr1;
    logic [9:0]  dout1;

    logic        v2, fen2, frd2;
    logic [1:0]  kin2;
    logic [15:0] din2;
    logic        dv2, rd2;
    logic [19:0] dout2;
    logic [1:0]  kerr2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    encoder_8b10b_lanes #(.LANES(1), .INIT_RD(1'b0)) u1 (
        .SBYTECLK(clk), .RESET(rst), .DIN_VALID(v1), .DIN(din1), .KIN(kin1),
        .FORCE_RD_EN(fen1), .FORCE_RD(frd1), .DOUT_VALID(dv1), .DOUT(dout1),
        .RD_OUT(rd1), .KERR(kerr1)
    );

    encoder_8b10b_lanes #(.LANES(2), .INIT_RD(1'b0)) u2 (
        .SBYTECLK(clk), .RESET(rst), .DIN_VALID(v2), .DIN(din2), .KIN(kin2),
        .FORCE_RD_EN(fen2), .FORCE_RD(frd2), .DOUT_VALID(dv2), .DOUT(dout2),
        .RD_OUT(rd2), .KERR(kerr2)
    );

    // abcdeifghj string (a = bit 9) to DOUT order (a = bit 0).
    function automatic logic [9:0] rev10(input logic [9:0] s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = s[9-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v1 = 0; kin1 = 0; fen1 = 0; frd1 = 0; din1 = 8'h00;
        v2 = 0; kin2 = 0; fen2 = 0; frd2 = 0; din2 = 16'h0000;

        // Reset state
        #3;
        check("rst_dout", 32'(dout1), 32'h0);
        check("rst_valid", 32'(dv1), 32'h0);
        check("rst_kerr", 32'(kerr1), 32'h0);
        check("rst_rd", 32'(rd1), 32'h0);
        @(negedge clk);
        rst = 0;

        // D.1.0 at RD-; dual lane {D.1.0, K.28.5} at RD-
        din1 = 8'h01; kin1 = 0; v1 = 1;
        din2 = 16'h01BC; kin2 = 2'b01; v2 = 1;
        tick();
        check("d1_0_dout", 32'(dout1), 32'(rev10(10'b011101_0100)));
        check("d1_0_valid", 32'(dv1), 32'h1);
        check("d1_0_rd", 32'(rd1), 32'h0);
        check("l2_dout", 32'(dout2),
              32'({rev10(10'b100010_1011), rev10(10'b001111_1010)}));
        check("l2_rd", 32'(rd2), 32'h1);
        check("l2_kerr", 32'(kerr2), 32'h0);

        // Idle: valid drops, DOUT holds; dual lane {K.23.7, K.28.0} at RD+
        v1 = 0;
        din2 = 16'hF71C; kin2 = 2'b11;
        tick();
        check("idle_valid", 32'(dv1), 32'h0);
        check("idle_hold", 32'(dout1), 32'(rev10(10'b011101_0100)));
        check("l2k_dout", 32'(dout2),
              32'({rev10(10'b000101_0111), rev10(10'b110000_1011)}));
        check("l2k_rd", 32'(rd2), 32'h1);
        check("l2k_kerr", 32'(kerr2), 32'h0);
        v2 = 0;

        // K.28.5 twice: RD- then RD+
        din1 = 8'hBC; kin1 = 1; v1 = 1;
        tick();
        check("k285a_dout", 32'(dout1), 32'(rev10(10'b001111_1010)));
        check("k285a_rd", 32'(rd1), 32'h1);
        tick();
        check("k285b_dout", 32'(dout1), 32'(rev10(10'b110000_0101)));
        check("k285b_rd", 32'(rd1), 32'h0);
        check("k285b_kerr", 32'(kerr1), 32'h0);

        // D.7.0 at RD-, then D.17.7 with forced RD- (A7)
        din1 = 8'h07; kin1 = 0;
        tick();
        check("d7_0_dout", 32'(dout1), 32'(rev10(10'b111000_1011)));
        check("d7_0_rd", 32'(rd1), 32'h1);
        din1 = 8'hF1; fen1 = 1; frd1 = 0;
        tick();
        check("d17_7_dout", 32'(dout1), 32'(rev10(10'b100011_0111)));
        check("d17_7_rd", 32'(rd1), 32'h1);

        // Illegal K.0.0 with forced RD-: data code plus KERR
        din1 = 8'h00; kin1 = 1;
        tick();
        check("kbad_dout", 32'(dout1), 32'(rev10(10'b100111_0100)));
        check("kbad_kerr", 32'(kerr1), 32'h1);
        check("kbad_rd", 32'(rd1), 32'h0);
        fen1 = 0; kin1 = 0; v1 = 0;
        tick();
        check("kbad_hold", 32'(kerr1), 32'h1);

        // Leave RD+ then reset mid-cycle
        din1 = 8'h07; v1 = 1;
        tick();
        check("pre_rst_rd", 32'(rd1), 32'h1);
        din1 = 8'h01;
        #2;
        rst = 1;
        #1;
        check("mid_rst_dout", 32'(dout1), 32'h0);
        check("mid_rst_valid", 32'(dv1), 32'h0);
        check("mid_rst_rd", 32'(rd1), 32'h0);
        #2;
        rst = 0;
        tick();
        check("post_rst_dout", 32'(dout1), 32'(rev10(10'b011101_0100)));
        check("post_rst_rd", 32'(rd1), 32'h0);
        v1 = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
